// File: rtl/lsu_pkg.sv
// lsu_pkg: shared FSM states, fault codes and memory control encodings for the LSU
package lsu_pkg;
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  localparam logic [1:0] FAULT_NONE     = 2'b00;
  localparam logic [1:0] FAULT_MISALIGN = 2'b01;
  localparam logic [1:0] FAULT_ACCESS   = 2'b10;
  localparam logic [1:0] FAULT_ILLEGAL  = 2'b11;
  localparam logic [2:0] RD_IDLE = 3'b000;
  localparam logic [2:0] RD_LB   = 3'b001;
  localparam logic [2:0] RD_LBU  = 3'b010;
  localparam logic [2:0] RD_LH   = 3'b011;
  localparam logic [2:0] RD_LHU  = 3'b100;
  localparam logic [2:0] RD_LW   = 3'b101;
  localparam logic [1:0] WR_IDLE = 2'b00;
  localparam logic [1:0] WR_B    = 2'b01;
  localparam logic [1:0] WR_H    = 2'b10;
  localparam logic [1:0] WR_W    = 2'b11;
endpackage

// File: rtl/lsu_decode.sv
// lsu_decode: maps (store, funct3, addr) to memory control codes and a fault code; LSU_MISALIGN_TRAP_EN enables misalignment faults
module lsu_decode
  import lsu_pkg::*;
#(
  parameter int XLEN = 32,
  parameter logic [XLEN-1:0] MEM_BASE = 32'h8000_0000,
  parameter logic [XLEN-1:0] MEM_TOP  = 32'h87FF_FFFF
) (
  input  logic            store,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] addr,
  output logic [2:0]      rd_ctrl,
  output logic [1:0]      wr_ctrl,
  output logic [1:0]      fault
);
  logic legal, misalign, oob;
  assign legal = store ? (funct3 inside {3'b000, 3'b001, 3'b010})
                       : (funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
`ifdef LSU_MISALIGN_TRAP_EN
  assign misalign = (funct3[1:0] == 2'b01 && addr[0]) || (funct3[1:0] == 2'b10 && addr[1:0] != 2'b00);
`else
  assign misalign = 1'b0;
`endif
  assign oob = addr < MEM_BASE || addr > MEM_TOP;
  assign fault = !legal ? FAULT_ILLEGAL : misalign ? FAULT_MISALIGN : oob ? FAULT_ACCESS : FAULT_NONE;
  assign rd_ctrl = (store || !legal) ? RD_IDLE :
                   funct3 == 3'b000 ? RD_LB  :
                   funct3 == 3'b100 ? RD_LBU :
                   funct3 == 3'b001 ? RD_LH  :
                   funct3 == 3'b101 ? RD_LHU : RD_LW;
  assign wr_ctrl = (!store || !legal) ? WR_IDLE :
                   funct3 == 3'b000 ? WR_B :
                   funct3 == 3'b001 ? WR_H : WR_W;
endmodule

// File: rtl/lsu.sv
// lsu: load/store unit with IDLE/ACCESS/RESP FSM; LSU_MISALIGN_TRAP_EN (in lsu_decode) enables misalignment faults
module lsu
  import lsu_pkg::*;
#(
  parameter int XLEN = 32,
  parameter logic [XLEN-1:0] MEM_BASE = 32'h8000_0000,
  parameter logic [XLEN-1:0] MEM_TOP  = 32'h87FF_FFFF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_store,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  input  logic            flush,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_rdata,
  output logic [1:0]      resp_fault,
  output logic [2:0]      data_sram_rd_ctrl,
  output logic [1:0]      data_sram_wr_ctrl,
  output logic [XLEN-1:0] data_sram_addr,
  output logic [XLEN-1:0] data_sram_wdata,
  input  logic [XLEN-1:0] data_sram_rdata
);
  state_t state;
  logic hs;
  logic [2:0] rd_q, dec_rd;
  logic [1:0] wr_q, dec_wr, dec_fault;
  logic [XLEN-1:0] addr_q, wdata_q;
  lsu_decode #(.XLEN(XLEN), .MEM_BASE(MEM_BASE), .MEM_TOP(MEM_TOP)) u_decode (
    .store(req_store), .funct3(req_funct3), .addr(req_addr),
    .rd_ctrl(dec_rd), .wr_ctrl(dec_wr), .fault(dec_fault)
  );
  assign req_ready = state == IDLE || (state == RESP && resp_ready);
  assign hs = req_valid && req_ready && !flush;
  assign data_sram_rd_ctrl = state == ACCESS ? rd_q : RD_IDLE;
  // A store must never reach memory in a cycle that is being flushed or reset
  assign data_sram_wr_ctrl = (state == ACCESS && !flush && !rst) ? wr_q : WR_IDLE;
  assign data_sram_addr = addr_q;
  assign data_sram_wdata = wdata_q;
  // FSM: accept, access memory for one cycle (skipped on fault), then hold the response
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      rd_q <= RD_IDLE;
      wr_q <= WR_IDLE;
      addr_q <= '0;
      wdata_q <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_fault <= FAULT_NONE;
    end else if (flush) begin
      state <= IDLE;
      resp_valid <= 1'b0;
    end else if (hs) begin
      state <= dec_fault == FAULT_NONE ? ACCESS : RESP;
      rd_q <= dec_rd;
      wr_q <= dec_wr;
      addr_q <= req_addr;
      wdata_q <= req_wdata;
      resp_valid <= dec_fault != FAULT_NONE;
      resp_rdata <= '0;
      resp_fault <= dec_fault;
    end else if (state == ACCESS) begin
      state <= RESP;
      resp_valid <= 1'b1;
      resp_rdata <= rd_q == RD_IDLE ? '0 : data_sram_rdata;
      resp_fault <= FAULT_NONE;
    end else if (state == RESP && resp_ready) begin
      state <= IDLE;
      resp_valid <= 1'b0;
    end
  end
endmodule

// File: doc/lsu.md
LSU -- requirements
Module: lsu

Interface
REQ-001 Parameter XLEN, default 32, data and address width.
REQ-002 Parameter MEM_BASE, default 32'h8000_0000, lowest legal data address.
REQ-003 Parameter MEM_TOP, default 32'h87FF_FFFF, highest legal data address.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 req_valid  input  1  EX stage presents a memory op.
REQ-007 req_ready  output  1  LSU accepts op this cycle.
REQ-008 req_store  input  1  1 = store, 0 = load.
REQ-009 req_funct3  input  3  RISC-V funct3 (size/sign).
REQ-010 req_addr  input  XLEN  effective byte address.
REQ-011 req_wdata  input  XLEN  store data, right-aligned.
REQ-012 flush  input  1  kill in-flight op.
REQ-013 resp_valid  output  1  result available.
REQ-014 resp_ready  input  1  WB stage consumes result.
REQ-015 resp_rdata  output  XLEN  extended load data; 0 for stores and faults.
REQ-016 resp_fault  output  2  00 none, 01 misaligned, 10 access fault, 11 illegal funct3.
REQ-017 data_sram_rd_ctrl  output  3  001 LB, 010 LBU, 011 LH, 100 LHU, 101 LW, 000 idle.
REQ-018 data_sram_wr_ctrl  output  2  01 byte, 10 half, 11 word, 00 idle.
REQ-019 data_sram_addr, data_sram_wdata  output  XLEN  memory address and write data.
REQ-020 data_sram_rdata  input  XLEN  combinational, already-extended read data from the data memory.

Function
REQ-021 The FSM SHALL have states IDLE, ACCESS and RESP.
REQ-022 The LSU SHALL assert req_ready in IDLE, and in RESP when resp_ready=1; otherwise it SHALL hold req_ready low.
REQ-023 On a handshake (req_valid & req_ready), the LSU SHALL register op, funct3, addr and wdata and SHALL decode size and legality.
REQ-024 Legal loads: funct3 000/001/010/100/101. Legal stores: 000/001/010. Any other funct3 SHALL yield fault 11.
REQ-025 Misaligned means half with addr[0]=1, or word with addr[1:0]!=0; it SHALL yield fault 01.
REQ-026 An address outside [MEM_BASE, MEM_TOP] SHALL yield fault 10.
REQ-027 Fault priority SHALL be 11 > 01 > 10.
REQ-028 A faulting op SHALL go directly to RESP, without driving the memory.
REQ-029 A legal op SHALL go to ACCESS for exactly one cycle.
REQ-030 In ACCESS, the LSU SHALL drive rd_ctrl (load) or wr_ctrl (store) from the registered op, and SHALL drive addr/wdata from the registers; in all other states ctrl SHALL be 0.
REQ-031 A load SHALL capture data_sram_rdata into resp_rdata at the end of ACCESS. A store's write SHALL occur at the edge ending ACCESS.
REQ-032 In RESP, resp_valid=1 and resp_rdata/resp_fault SHALL be held stable until resp_ready.
REQ-033 On RESP & resp_ready with no new request, the FSM SHALL go to IDLE; with a new request it SHALL go to ACCESS (legal) or stay in RESP (fault).
REQ-034 Latency SHALL be: accept at cycle N, resp_valid at N+2 for legal ops and N+1 for faults; peak throughput one op per 2 cycles.
REQ-035 On flush, the FSM SHALL go to IDLE next cycle, resp_valid SHALL drop, and a store's wr_ctrl SHALL be combinationally gated to 00 in that cycle; any request presented with flush SHALL be ignored.
REQ-036 data_sram_wdata SHALL be req_wdata unmodified; the memory selects the low bytes.

Reset
REQ-037 With rst=1 at a rising edge: state=IDLE; resp_valid=0, resp_rdata=0, resp_fault=00; registered addr/wdata=0; rd_ctrl=000 and wr_ctrl=00.
REQ-038 rst SHALL take priority over flush and handshakes, and a store in ACCESS SHALL have wr_ctrl forced to 00 while rst=1.

Configuration
REQ-039 The macro LSU_MISALIGN_TRAP_EN SHALL select misalignment handling.
REQ-040 With LSU_MISALIGN_TRAP_EN defined, REQ-025 applies.
REQ-041 Without LSU_MISALIGN_TRAP_EN, misaligned ops SHALL be treated as legal and issued unchanged to the byte-addressed memory; fault 01 SHALL never occur.

Structure
REQ-042 Package lsu_pkg SHALL hold the state enum, the fault-code constants and the rd_ctrl/wr_ctrl encodings.
REQ-043 Combinational sub-module lsu_decode SHALL map (store, funct3, addr) to ctrl codes and a fault code.

Verification
REQ-044 Load LW at 0x8000_0010, memory holds 0xDEADBEEF: rd_ctrl=101 in cycle N+1; resp_rdata=0xDEADBEEF and fault=00 at N+2.
REQ-045 Store SB of 0x1234_56AB at 0x8000_0003: wr_ctrl=01 for exactly one cycle; a following LBU at the same address returns 0x0000_00AB.
REQ-046 LH at 0x8000_0001: fault=01 at N+1 and no memory activity with the macro defined; without it, rd_ctrl=011 is issued and fault=00.
REQ-047 LW at 0x0000_0100 gives fault=10. A store with funct3=011 gives fault=11, even when the address is misaligned.
REQ-048 Hold resp_ready=0 for 3 cycles: response stays stable and req_ready=0. Assert flush during a store ACCESS: wr_ctrl=00 and memory unchanged. Apply rst mid-ACCESS: all outputs return to reset values next cycle.
